adder_sum_pipe: RTL

//   Final prefix level and sum stage of the parallel-prefix adder. It sits directly downstream of adder_stage5.
//   - Takes the span-8 group generate/propagate vectors from adder_stage5.
//   - Completes the span-16 combine.
//   - Folds in carry-in and forms sum plus NZCV flags.
//   - Pipelined over two registered stages, with a valid/ready handshake toward the execute unit.

---
 rtl/adder_sum_pipe_pkg.sv | 24 ++
 rtl/adder_sum_pipe_gp_cell.sv | 15 +
 rtl/adder_sum_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/adder_sum_pipe_pkg.sv
// Shared constants and flag payload type for the parallel-prefix adder sum stage.
package adder_sum_pipe_pkg;

  // Datapath width of the adder; the sum stage only supports this value.
  localparam int unsigned LEN_DATA = 32;

  // Default sideband tag width carried alongside each operation.
  localparam int unsigned SIDEBAND_TAG_W = 4;

  // Bit positions of the NZCV flags inside flags_out.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // NZCV flag bundle; field order matches the FLAG_* bit positions.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage : adder_sum_pipe_pkg

// File: rtl/adder_sum_pipe_gp_cell.sv
// Prefix combine cell: merges a left group (G,P) with the adjacent right group.
module adder_sum_pipe_gp_cell (
  input  logic g_left,
  input  logic p_left,
  input  logic g_right,
  input  logic p_right,
  output logic g_out,
  output logic p_out
);

  // Left group generates, or propagates a generate from the right group.
  assign g_out = g_left | (p_left & g_right);
  assign p_out = p_left & p_right;

endmodule : adder_sum_pipe_gp_cell

// File: rtl/adder_sum_pipe.sv
// Final span-16 prefix level plus carry-in fold, sum and NZCV flags.
// Two registered stages with a valid/ready handshake toward execute.
module adder_sum_pipe
  import adder_sum_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = LEN_DATA,
  parameter int unsigned TAG_W = SIDEBAND_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] generate_in,
  input  logic [WIDTH-1:0] propogate_in,
  input  logic [WIDTH-1:0] half_sum_in,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic [3:0]       flags_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned HALF = WIDTH / 2;

  // The prefix tree upstream is built for a 32-bit datapath only.
  if (WIDTH != 32) begin : g_width_check
    $error("adder_sum_pipe: WIDTH must be 32");
  end

  // Handshake and stage control
  logic v1;
  logic v2;
  logic adv1;
  logic accept;
  logic load2;

  // Stage A contents
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] hs1;
  logic             cin1;
  logic [TAG_W-1:0] tag1;

  // Span-16 combine results and stage B combinational results
  logic [WIDTH-1:0] g_comb;
  logic [WIDTH-1:0] p_comb;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  flags_t           flags_c;

  // Stage B advances when it is empty or being drained; stage A follows.
  assign adv1     = !v2 || out_ready;
  assign in_ready = !v1 || adv1;
  assign accept   = in_valid && in_ready && !flush;
  assign load2    = v1 && adv1 && !flush;
  assign out_valid = v2;

  // Lower half already spans down to bit 0 and passes straight through.
  assign g_comb[HALF-1:0] = generate_in[HALF-1:0];
  assign p_comb[HALF-1:0] = propogate_in[HALF-1:0];

  // Upper half merges with the full lower-half group at bit HALF-1.
  for (genvar i = HALF; i < WIDTH; i++) begin : g_span16
    adder_sum_pipe_gp_cell u_gp_cell (
      .g_left  (generate_in[i]),
      .p_left  (propogate_in[i]),
      .g_right (generate_in[HALF-1]),
      .p_right (propogate_in[HALF-1]),
      .g_out   (g_comb[i]),
      .p_out   (p_comb[i])
    );
  end

  // Fold carry-in into the full-span prefix to get every bit's carry, then sum and flags.
  always_comb begin
    carry     = {g1 | (p1 & {WIDTH{cin1}}), cin1};
    sum_c     = hs1 ^ carry[WIDTH-1:0];
    flags_c   = '0;
    flags_c.n = sum_c[WIDTH-1];
    flags_c.z = (sum_c == '0);
    flags_c.c = carry[WIDTH];
    flags_c.v = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Stage A register: captures combined G/P and sideband on an input accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      g1   <= '0;
      p1   <= '0;
      hs1  <= '0;
      cin1 <= 1'b0;
      tag1 <= '0;
    end else begin
      if (flush) begin
        v1 <= 1'b0;
      end else if (accept) begin
        v1 <= 1'b1;
      end else if (load2) begin
        v1 <= 1'b0;
      end
      if (accept) begin
        g1   <= g_comb;
        p1   <= p_comb;
        hs1  <= half_sum_in;
        cin1 <= carry_in;
        tag1 <= tag_in;
      end
    end
  end

  // Stage B register: holds the result stable until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      sum_out   <= '0;
      flags_out <= '0;
      tag_out   <= '0;
    end else begin
      if (flush) begin
        v2 <= 1'b0;
      end else if (load2) begin
        v2 <= 1'b1;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
      if (load2) begin
        sum_out   <= sum_c;
        flags_out <= flags_c;
        tag_out   <= tag1;
      end
    end
  end

endmodule : adder_sum_pipe
